// File: rtl/bank_isu_pkg.sv
// Shared types and helpers for the bank ISU linefill tracker.
//   lf_id_t     : {set, way} linefill identifier, sized for the widest
//                 supported geometry. Users truncate it to their own widths.
//   rid_pack    : {set, way} -> flat BIU read id for a given way width.
//   rid_unpack  : flat BIU read id -> {set, way} for a given way width.
//   DEF_*       : default cache geometry and outstanding cap.
package bank_isu_pkg;

    localparam int DEF_SET_NUM         = 8;
    localparam int DEF_WAY_NUM         = 8;
    localparam int DEF_MAX_OUTSTANDING = 16;

    localparam int IDX_MAX_W = 16;
    localparam int ID_MAX_W  = 2 * IDX_MAX_W;

    typedef struct packed {
        logic [IDX_MAX_W-1:0] set;
        logic [IDX_MAX_W-1:0] way;
    } lf_id_t;

    function automatic logic [ID_MAX_W-1:0] rid_pack(input lf_id_t id, input int way_w);
        return (ID_MAX_W'(id.set) << way_w) | ID_MAX_W'(id.way);
    endfunction

    function automatic lf_id_t rid_unpack(input logic [ID_MAX_W-1:0] rid, input int way_w);
        lf_id_t              id;
        logic [ID_MAX_W-1:0] mask;
        mask   = (ID_MAX_W'(1) << way_w) - ID_MAX_W'(1);
        id.way = IDX_MAX_W'(rid & mask);
        id.set = IDX_MAX_W'(rid >> way_w);
        return id;
    endfunction

endpackage

// File: rtl/bank_isu_onehot_dcd.sv
// Binary to one-hot decoder.
//   idx_i    : N-bit binary index
//   onehot_o : 2**N-bit vector with exactly bit idx_i set
module bank_isu_onehot_dcd #(
    parameter int N = 6
) (
    input  logic [N-1:0]      idx_i,
    output logic [(1<<N)-1:0] onehot_o
);

    localparam int M = 1 << N;

    assign onehot_o = M'(1) << idx_i;

endmodule

// File: rtl/bank_isu_linefill_tracker.sv
// Tracks outstanding linefills per (set, way), caps the number in flight,
// consumes (possibly interleaved) multi-beat BIU read returns and emits a
// registered fill-done wakeup plus sticky protocol-error flags.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   alloc_valid_i/alloc_ready_o       HTU allocation handshake
//   alloc_set_i, alloc_way_i          line being allocated
//   lookup_set_i, lookup_way_i        issue-queue query
//   lookup_inflight_o                 queried line outstanding (registered state)
//   biu_rvalid_i/biu_rready_o         BIU read beat handshake (ready tied 1)
//   biu_rid_i, biu_rlast_i            {set,way} id and last-beat marker
//   fill_done_valid_o/_set_o/_way_o   one-cycle completion wakeup
//   outstanding_cnt_o                 linefills in flight
//   err_dup_alloc_o, err_orphan_resp_o sticky error flags
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. ready depends only on registered state, never on the
// same-cycle valid; valid carries its payload unchanged while asserted.
module bank_isu_linefill_tracker
    import bank_isu_pkg::*;
#(
    parameter int SET_NUM         = DEF_SET_NUM,
    parameter int WAY_NUM         = DEF_WAY_NUM,
    parameter int SET_W           = $clog2(SET_NUM),
    parameter int WAY_W           = $clog2(WAY_NUM),
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  logic [SET_W-1:0]       alloc_set_i,
    input  logic [WAY_W-1:0]       alloc_way_i,
    input  logic [SET_W-1:0]       lookup_set_i,
    input  logic [WAY_W-1:0]       lookup_way_i,
    output logic                   lookup_inflight_o,
    input  logic                   biu_rvalid_i,
    output logic                   biu_rready_o,
    input  logic [SET_W+WAY_W-1:0] biu_rid_i,
    input  logic                   biu_rlast_i,
    output logic                   fill_done_valid_o,
    output logic [SET_W-1:0]       fill_done_set_o,
    output logic [WAY_W-1:0]       fill_done_way_o,
    output logic [CNT_W-1:0]       outstanding_cnt_o,
    output logic                   err_dup_alloc_o,
    output logic                   err_orphan_resp_o
);

    localparam int ID_W  = SET_W + WAY_W;
    localparam int LINES = 1 << ID_W;

    logic [LINES-1:0] inflight;
    logic [LINES-1:0] inflight_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [LINES-1:0] alloc_oh;
    logic [LINES-1:0] rsp_oh;
    logic [LINES-1:0] lookup_oh;
    logic [ID_W-1:0]  alloc_id;
    logic [ID_W-1:0]  lookup_id;

    lf_id_t           alloc_lf;
    lf_id_t           lookup_lf;
    lf_id_t           rsp_lf;
    logic [SET_W-1:0] rsp_set;
    logic [WAY_W-1:0] rsp_way;
    logic             unused_rsp_bits;

    logic alloc_fire;
    logic alloc_hit;
    logic alloc_new;
    logic last_beat;
    logic rsp_hit;
    logic cmpl_fire;
    logic orphan;
    logic dup;

    always_comb begin
        alloc_lf.set  = IDX_MAX_W'(alloc_set_i);
        alloc_lf.way  = IDX_MAX_W'(alloc_way_i);
        lookup_lf.set = IDX_MAX_W'(lookup_set_i);
        lookup_lf.way = IDX_MAX_W'(lookup_way_i);
        alloc_id      = ID_W'(rid_pack(alloc_lf, WAY_W));
        lookup_id     = ID_W'(rid_pack(lookup_lf, WAY_W));
        rsp_lf        = rid_unpack(ID_MAX_W'(biu_rid_i), WAY_W);
        rsp_set       = SET_W'(rsp_lf.set);
        rsp_way       = WAY_W'(rsp_lf.way);
    end

    // Upper bits of the wide struct are zero for this geometry.
    assign unused_rsp_bits = ^{rsp_lf.set, rsp_lf.way};

    bank_isu_onehot_dcd #(.N(ID_W)) u_dcd_alloc  (.idx_i(alloc_id),  .onehot_o(alloc_oh));
    bank_isu_onehot_dcd #(.N(ID_W)) u_dcd_rsp    (.idx_i(biu_rid_i), .onehot_o(rsp_oh));
    bank_isu_onehot_dcd #(.N(ID_W)) u_dcd_lookup (.idx_i(lookup_id), .onehot_o(lookup_oh));

    // No completion bypass: ready is a pure function of the registered count.
    assign alloc_ready_o     = (cnt < CNT_W'(MAX_OUTSTANDING));
    assign biu_rready_o      = 1'b1;
    assign lookup_inflight_o = |(inflight & lookup_oh);
    assign outstanding_cnt_o = cnt;

    assign alloc_fire = alloc_valid_i & alloc_ready_o;
    assign alloc_hit  = |(inflight & alloc_oh);
    assign last_beat  = biu_rvalid_i & biu_rlast_i;
    assign rsp_hit    = |(inflight & rsp_oh);
    assign cmpl_fire  = last_beat & rsp_hit;
    assign orphan     = last_beat & ~rsp_hit;

    // A same-cycle completion of the same line frees it first, so the
    // re-allocation is a legitimate new linefill rather than a duplicate.
    assign dup       = alloc_fire & alloc_hit & ~(cmpl_fire & (alloc_id == biu_rid_i));
    assign alloc_new = alloc_fire & ~dup;

    always_comb begin
        inflight_nxt = inflight;
        if (cmpl_fire) begin
            inflight_nxt = inflight_nxt & ~rsp_oh;
        end
        if (alloc_fire) begin
            inflight_nxt = inflight_nxt | alloc_oh;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        case ({alloc_new, cmpl_fire})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight          <= '0;
            cnt               <= '0;
            fill_done_valid_o <= 1'b0;
            fill_done_set_o   <= '0;
            fill_done_way_o   <= '0;
            err_dup_alloc_o   <= 1'b0;
            err_orphan_resp_o <= 1'b0;
        end else begin
            inflight          <= inflight_nxt;
            cnt               <= cnt_nxt;
            fill_done_valid_o <= cmpl_fire;
            if (cmpl_fire) begin
                fill_done_set_o <= rsp_set;
                fill_done_way_o <= rsp_way;
            end
            if (dup) begin
                err_dup_alloc_o <= 1'b1;
            end
            if (orphan) begin
                err_orphan_resp_o <= 1'b1;
            end
        end
    end

    a_cnt_popcount : assert property (@(posedge clk_i) disable iff (rst_i)
        cnt == CNT_W'($countones(inflight)));
    a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        cnt <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_bank_isu_linefill_tracker.sv
module tb_bank_isu_linefill_tracker;

    localparam int MAXO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       alloc_valid;
    logic       alloc_ready;
    logic [2:0] alloc_set;
    logic [2:0] alloc_way;
    logic [2:0] lookup_set;
    logic [2:0] lookup_way;
    logic       lookup_inflight;
    logic       biu_rvalid;
    logic       biu_rready;
    logic [5:0] biu_rid;
    logic       biu_rlast;
    logic       fd_valid;
    logic [2:0] fd_set;
    logic [2:0] fd_way;
    logic [4:0] out_cnt;
    logic       err_dup;
    logic       err_orph;

    bank_isu_linefill_tracker dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .alloc_valid_i     (alloc_valid),
        .alloc_ready_o     (alloc_ready),
        .alloc_set_i       (alloc_set),
        .alloc_way_i       (alloc_way),
        .lookup_set_i      (lookup_set),
        .lookup_way_i      (lookup_way),
        .lookup_inflight_o (lookup_inflight),
        .biu_rvalid_i      (biu_rvalid),
        .biu_rready_o      (biu_rready),
        .biu_rid_i         (biu_rid),
        .biu_rlast_i       (biu_rlast),
        .fill_done_valid_o (fd_valid),
        .fill_done_set_o   (fd_set),
        .fill_done_way_o   (fd_way),
        .outstanding_cnt_o (out_cnt),
        .err_dup_alloc_o   (err_dup),
        .err_orphan_resp_o (err_orph)
    );

    // ---------------- scoreboard / model ----------------
    logic [5:0] exp_q[$];
    logic       m_inf[64];
    int         m_cnt;
    logic       m_dup;
    logic       m_orph;
    int         total = 0;
    int         bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_inf[i] = 1'b0;
        m_cnt  = 0;
        m_dup  = 1'b0;
        m_orph = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state();
        logic [5:0] e;
        if (fd_valid) begin
            if (exp_q.size() == 0) begin
                check_val("fd_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("fd_id", {26'd0, fd_set, fd_way}, {26'd0, e});
            end
        end
        check_val("fd_pending", exp_q.size(), 0);
        check_val("cnt", out_cnt, m_cnt);
        check_val("err_dup", err_dup, m_dup);
        check_val("err_orph", err_orph, m_orph);
        check_val("rready", biu_rready, 1);
    endtask

    task automatic check_lookup(input logic [2:0] s, input logic [2:0] w);
        lookup_set = s;
        lookup_way = w;
        #1;
        check_val("lookup", lookup_inflight, m_inf[{s, w}]);
    endtask

    // ---------------- driver ----------------
    // Called at #1 after a rising edge; drives one cycle and checks after the next edge.
    task automatic step(input logic av, input logic [2:0] as, input logic [2:0] aw,
                        input logic rv, input logic [2:0] rs, input logic [2:0] rw,
                        input logic rl);
        logic ready, af, cf, orph, dup;
        int   ia, ir;
        alloc_valid = av;
        alloc_set   = as;
        alloc_way   = aw;
        biu_rvalid  = rv;
        biu_rid     = {rs, rw};
        biu_rlast   = rl;
        ia    = int'({as, aw});
        ir    = int'({rs, rw});
        ready = (m_cnt < MAXO);
        check_val("alloc_ready", alloc_ready, ready);
        af   = av & ready;
        cf   = rv & rl & m_inf[ir];
        orph = rv & rl & ~m_inf[ir];
        dup  = af & m_inf[ia] & ~(cf & (ia == ir));
        if (cf) begin
            m_inf[ir] = 1'b0;
            m_cnt--;
            exp_q.push_back({rs, rw});
        end
        if (af) begin
            if (!dup) m_cnt++;
            m_inf[ia] = 1'b1;
        end
        if (dup)  m_dup  = 1'b1;
        if (orph) m_orph = 1'b1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [2:0] s, input logic [2:0] w);
        step(1, s, w, 0, 0, 0, 0);
    endtask

    task automatic beat(input logic [2:0] s, input logic [2:0] w, input logic last);
        step(0, 0, 0, 1, s, w, last);
    endtask

    task automatic do_reset(input logic rlast_during);
        rst         = 1'b1;
        alloc_valid = 1'b1;
        alloc_set   = 3'd6;
        alloc_way   = 3'd6;
        biu_rvalid  = rlast_during;
        biu_rid     = {3'd1, 3'd1};
        biu_rlast   = rlast_during;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        alloc_valid = 1'b0;
        biu_rvalid  = 1'b0;
        biu_rlast   = 1'b0;
        model_clear();
        check_val("rst_fd_valid", fd_valid, 0);
        check_val("rst_fd_set", fd_set, 0);
        check_val("rst_fd_way", fd_way, 0);
        check_state();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        alloc_valid = 0; alloc_set = 0; alloc_way = 0;
        lookup_set = 0; lookup_way = 0;
        biu_rvalid = 0; biu_rid = 0; biu_rlast = 0;
        model_clear();

        // basic alloc / complete
        do_reset(0);
        check_lookup(3, 5);
        alloc(3, 5);
        check_lookup(3, 5);
        beat(3, 5, 1);
        check_lookup(3, 5);
        idle();

        // fill to the cap; alloc + completion at full keeps ready low that cycle
        for (int i = 0; i < 16; i++) alloc(3'(i), 3'((i >> 3) + 1));
        step(1, 3'd0, 3'd0, 1, 3'd0, 3'd1, 1);
        check_lookup(0, 0);
        check_lookup(0, 1);
        idle();
        for (int i = 1; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) beat(3'(i), 3'((i >> 3) + 1), 0);
            beat(3'(i), 3'((i >> 3) + 1), 1);
        end
        idle();

        // interleaved beats: A=(4,6), B=(5,7)
        alloc(4, 6);
        alloc(5, 7);
        beat(4, 6, 0);
        beat(5, 7, 0);
        beat(4, 6, 0);
        beat(5, 7, 1);
        beat(4, 6, 1);
        idle();

        // same-cycle alloc and completion on the same line
        alloc(2, 2);
        step(1, 3'd2, 3'd2, 1, 3'd2, 3'd2, 1);
        check_lookup(2, 2);
        beat(2, 2, 1);
        idle();

        // orphan and duplicate
        beat(7, 0, 1);
        idle();
        alloc(1, 1);
        alloc(1, 1);
        check_lookup(1, 1);
        idle();

        // reset mid-linefill with 3 outstanding, rlast present during reset
        alloc(4, 4);
        alloc(6, 1);
        beat(4, 4, 0);
        do_reset(1);
        check_lookup(1, 1);
        check_lookup(4, 4);
        check_lookup(6, 1);
        beat(4, 4, 1);
        idle();

        // random traffic over a small pool of lines
        do_reset(0);
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 2; w++)
                check_lookup(3'(s), 3'(w));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
